// File: rtl/r_rename_ckpt_pkg.sv
// rtl/r_rename_ckpt_pkg.sv - shared parameters, derived widths and FSM state for the rename checkpoint block
package r_rename_ckpt_pkg;
    localparam int RN_WIDTH_DEF  = 2;
    localparam int ARF_DEPTH_DEF = 32;
    localparam int PRF_DEPTH_DEF = 64;
    localparam int CM_WIDTH_DEF  = 2;
    localparam int AW_DEF        = $clog2(ARF_DEPTH_DEF);
    localparam int PW_DEF        = $clog2(PRF_DEPTH_DEF);
    localparam int FL_DEF        = PRF_DEPTH_DEF - ARF_DEPTH_DEF;

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_RECOVER = 1'b1
    } state_e;
endpackage

// File: rtl/r_rename_freelist.sv
// rtl/r_rename_freelist.sv - circular physical-register free list with speculative and committed heads
module r_rename_freelist
    import r_rename_ckpt_pkg::*;
#(
    parameter int FL       = FL_DEF,
    parameter int PW       = PW_DEF,
    parameter int BASE     = ARF_DEPTH_DEF,
    parameter int RN_WIDTH = RN_WIDTH_DEF,
    parameter int CM_WIDTH = CM_WIDTH_DEF,
    localparam int FW      = $clog2(FL)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [FW:0]            alloc_n_i,
    output logic [RN_WIDTH*PW-1:0] alloc_preg_o,
    input  logic [CM_WIDTH-1:0]    push_valid_i,
    input  logic [CM_WIDTH*PW-1:0] push_preg_i,
    input  logic                   restore_i,
    output logic [FW:0]            count_o
);
    logic [PW-1:0] mem_q [FL];
    logic [PW-1:0] mem_d [FL];
    logic [FW-1:0] shead_q, shead_d, chead_q, chead_d, tail_q, tail_d;
    logic [FW:0]   cnt_q, cnt_d, push_n, span;

    // FL need not be a power of two, so wrap by compare-and-subtract.
    function automatic logic [FW-1:0] wrap_add(input logic [FW-1:0] ptr, input logic [FW:0] n);
        logic [FW:0] s;
        s = {1'b0, ptr} + n;
        if (s >= (FW+1)'(FL)) s = s - (FW+1)'(FL);
        return s[FW-1:0];
    endfunction

    always_comb begin
        logic [FW-1:0] wptr;
        mem_d  = mem_q;
        push_n = '0;
        wptr   = tail_q;
        for (int p = 0; p < CM_WIDTH; p++) begin
            if (push_valid_i[p]) begin
                mem_d[wptr] = push_preg_i[p*PW +: PW];
                wptr        = wrap_add(wptr, (FW+1)'(1));
                push_n      = push_n + (FW+1)'(1);
            end
        end
        tail_d  = wptr;
        chead_d = wrap_add(chead_q, push_n);
        span    = (tail_d >= chead_d) ? ({1'b0, tail_d} - {1'b0, chead_d})
                                      : ({1'b0, tail_d} + (FW+1)'(FL) - {1'b0, chead_d});
        if (restore_i) begin
            shead_d = chead_d;
            cnt_d   = (span == '0) ? (FW+1)'(FL) : span;
        end else begin
            shead_d = wrap_add(shead_q, alloc_n_i);
            cnt_d   = cnt_q + push_n - alloc_n_i;
        end
    end

    always_comb begin
        alloc_preg_o = '0;
        for (int k = 0; k < RN_WIDTH; k++)
            alloc_preg_o[k*PW +: PW] = mem_q[wrap_add(shead_q, (FW+1)'(k))];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < FL; k++) mem_q[k] <= PW'(BASE + k);
            shead_q <= '0;
            chead_q <= '0;
            tail_q  <= '0;
            cnt_q   <= (FW+1)'(FL);
        end else begin
            mem_q   <= mem_d;
            shead_q <= shead_d;
            chead_q <= chead_d;
            tail_q  <= tail_d;
            cnt_q   <= cnt_d;
        end
    end

    assign count_o = cnt_q;

    a_fl_no_overflow: assert property (@(posedge clk) disable iff (rst)
        restore_i || ({1'b0, cnt_q} + {1'b0, push_n} <= {1'b0, alloc_n_i} + (FW+2)'(FL)));
endmodule

// File: rtl/r_rename_ckpt.sv
// rtl/r_rename_ckpt.sv - register rename stage with speculative/architectural RAT checkpoint recovery
module r_rename_ckpt
    import r_rename_ckpt_pkg::*;
#(
    parameter int RN_WIDTH  = RN_WIDTH_DEF,
    parameter int ARF_DEPTH = ARF_DEPTH_DEF,
    parameter int PRF_DEPTH = PRF_DEPTH_DEF,
    parameter int CM_WIDTH  = CM_WIDTH_DEF,
    localparam int AW       = $clog2(ARF_DEPTH),
    localparam int PW       = $clog2(PRF_DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [RN_WIDTH-1:0]      in_mask_i,
    input  logic [RN_WIDTH*2*AW-1:0] in_src_i,
    input  logic [RN_WIDTH*AW-1:0]   in_dst_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [RN_WIDTH-1:0]      out_mask_o,
    output logic [RN_WIDTH*2*PW-1:0] out_psrc_o,
    output logic [RN_WIDTH*PW-1:0]   out_pdst_o,
    output logic [RN_WIDTH*PW-1:0]   out_pold_o,
    input  logic [CM_WIDTH-1:0]      cm_valid_i,
    input  logic [CM_WIDTH*AW-1:0]   cm_dst_i,
    input  logic [CM_WIDTH*PW-1:0]   cm_pdst_i,
    input  logic [CM_WIDTH*PW-1:0]   cm_pold_i,
    input  logic                     flush_i,
    output logic                     flush_ack_o
);
    localparam int FL = PRF_DEPTH - ARF_DEPTH;
    localparam int FW = $clog2(FL);

    state_e                   state_q;
    logic                     flush_ack_q, out_valid_q;
    logic [RN_WIDTH-1:0]      out_mask_q;
    logic [RN_WIDTH*2*PW-1:0] out_psrc_q;
    logic [RN_WIDTH*PW-1:0]   out_pdst_q, out_pold_q;
    logic [PW-1:0]            spec_rat_q [ARF_DEPTH];
    logic [PW-1:0]            spec_rat_d [ARF_DEPTH];
    logic [PW-1:0]            arch_rat_q [ARF_DEPTH];
    logic [PW-1:0]            arch_rat_d [ARF_DEPTH];
    logic [RN_WIDTH*PW-1:0]   fl_alloc_preg;
    logic [FW:0]              fl_count, alloc_n;
    logic [CM_WIDTH-1:0]      cm_push;
    logic [RN_WIDTH-1:0]      need;
    logic [RN_WIDTH*PW-1:0]   pdst_c, pold_c;
    logic [RN_WIDTH*2*PW-1:0] psrc_c;
    logic                     accept, recover;

    assign recover    = (state_q == ST_RECOVER);
    // Readiness ignores how many slots actually need a preg.
    assign in_ready_o = !recover && !flush_i && (fl_count >= (FW+1)'(RN_WIDTH))
                        && (!out_valid_q || out_ready_i);
    assign accept     = in_valid_i && in_ready_o;

    always_comb begin
        int unsigned rank;
        logic [AW-1:0] a;
        logic [PW-1:0] p;
        rank   = 0;
        need   = '0;
        pdst_c = '0;
        pold_c = '0;
        psrc_c = '0;
        for (int j = 0; j < RN_WIDTH; j++) begin
            need[j] = in_mask_i[j] && (in_dst_i[j*AW +: AW] != '0);
            if (need[j]) begin
                pdst_c[j*PW +: PW] = fl_alloc_preg[rank*PW +: PW];
                rank++;
            end
        end
        alloc_n = accept ? (FW+1)'(rank) : '0;
        // Later matching slots overwrite earlier ones, so the youngest producer wins.
        for (int j = 0; j < RN_WIDTH; j++) begin
            for (int s = 0; s < 2; s++) begin
                a = in_src_i[(2*j+s)*AW +: AW];
                p = spec_rat_q[a];
                for (int i = 0; i < j; i++)
                    if (need[i] && in_dst_i[i*AW +: AW] == a) p = pdst_c[i*PW +: PW];
                psrc_c[(2*j+s)*PW +: PW] = p;
            end
            if (need[j]) begin
                a = in_dst_i[j*AW +: AW];
                p = spec_rat_q[a];
                for (int i = 0; i < j; i++)
                    if (need[i] && in_dst_i[i*AW +: AW] == a) p = pdst_c[i*PW +: PW];
                pold_c[j*PW +: PW] = p;
            end
        end
    end

    always_comb begin
        cm_push    = '0;
        arch_rat_d = arch_rat_q;
        for (int p = 0; p < CM_WIDTH; p++) begin
            cm_push[p] = cm_valid_i[p] && (cm_dst_i[p*AW +: AW] != '0);
            if (cm_push[p]) arch_rat_d[cm_dst_i[p*AW +: AW]] = cm_pdst_i[p*PW +: PW];
        end
        spec_rat_d = spec_rat_q;
        if (recover) begin
            spec_rat_d = arch_rat_d;
        end else if (accept) begin
            for (int j = 0; j < RN_WIDTH; j++)
                if (need[j]) spec_rat_d[in_dst_i[j*AW +: AW]] = pdst_c[j*PW +: PW];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ARF_DEPTH; i++) begin
                spec_rat_q[i] <= PW'(i);
                arch_rat_q[i] <= PW'(i);
            end
        end else begin
            spec_rat_q <= spec_rat_d;
            arch_rat_q <= arch_rat_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            flush_ack_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_mask_q  <= '0;
            out_psrc_q  <= '0;
            out_pdst_q  <= '0;
            out_pold_q  <= '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (flush_i) begin
                        state_q     <= ST_RECOVER;
                        flush_ack_q <= 1'b1;
                        out_valid_q <= 1'b0;
                    end else if (accept) begin
                        out_valid_q <= 1'b1;
                        out_mask_q  <= in_mask_i;
                        out_psrc_q  <= psrc_c;
                        out_pdst_q  <= pdst_c;
                        out_pold_q  <= pold_c;
                    end else if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_RUN;
                    flush_ack_q <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    r_rename_freelist #(
        .FL       (FL),
        .PW       (PW),
        .BASE     (ARF_DEPTH),
        .RN_WIDTH (RN_WIDTH),
        .CM_WIDTH (CM_WIDTH)
    ) u_freelist (
        .clk          (clk),
        .rst          (rst),
        .alloc_n_i    (alloc_n),
        .alloc_preg_o (fl_alloc_preg),
        .push_valid_i (cm_push),
        .push_preg_i  (cm_pold_i),
        .restore_i    (recover),
        .count_o      (fl_count)
    );

    assign out_valid_o = out_valid_q;
    assign out_mask_o  = out_mask_q;
    assign out_psrc_o  = out_psrc_q;
    assign out_pdst_o  = out_pdst_q;
    assign out_pold_o  = out_pold_q;
    assign flush_ack_o = flush_ack_q;
endmodule

// File: tb/tb_r_rename_ckpt.sv
// tb/tb_r_rename_ckpt.sv - randomized bench for r_rename_ckpt against a sequential map/queue reference model
module tb_r_rename_ckpt;
    import r_rename_ckpt_pkg::*;
    localparam int RN = RN_WIDTH_DEF, ARF = ARF_DEPTH_DEF, CM = CM_WIDTH_DEF;
    localparam int AW = AW_DEF, PW = PW_DEF, FL = FL_DEF;

    logic clk = 1'b0;
    logic rst;
    logic in_valid_i, in_ready_o, out_valid_o, out_ready_i, flush_i, flush_ack_o;
    logic [RN-1:0] in_mask_i, out_mask_o;
    logic [RN*2*AW-1:0] in_src_i;
    logic [RN*AW-1:0] in_dst_i;
    logic [RN*2*PW-1:0] out_psrc_o;
    logic [RN*PW-1:0] out_pdst_o, out_pold_o;
    logic [CM-1:0] cm_valid_i;
    logic [CM*AW-1:0] cm_dst_i;
    logic [CM*PW-1:0] cm_pdst_i, cm_pold_i;

    always #5 clk = ~clk;

    r_rename_ckpt dut (
        .clk(clk), .rst(rst),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_mask_i(in_mask_i),
        .in_src_i(in_src_i), .in_dst_i(in_dst_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_mask_o(out_mask_o),
        .out_psrc_o(out_psrc_o), .out_pdst_o(out_pdst_o), .out_pold_o(out_pold_o),
        .cm_valid_i(cm_valid_i), .cm_dst_i(cm_dst_i), .cm_pdst_i(cm_pdst_i), .cm_pold_i(cm_pold_i),
        .flush_i(flush_i), .flush_ack_o(flush_ack_o)
    );

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct { int dst; int pdst; int pold; } uop_t;
    int   m_spec [ARF];
    int   m_arch [ARF];
    int   m_sfl [$];
    int   m_afl [$];
    uop_t m_inflight [$];
    bit   m_recover, m_ovalid;
    logic [RN-1:0] m_omask;
    logic [RN*2*PW-1:0] m_opsrc;
    logic [RN*PW-1:0] m_opdst, m_opold;

    bit s_valid, s_oready, s_flush;
    logic [RN-1:0] s_mask;
    int s_dst [RN];
    int s_src [RN][2];
    int s_cm [CM];

    task automatic model_reset();
        for (int i = 0; i < ARF; i++) begin m_spec[i] = i; m_arch[i] = i; end
        m_sfl.delete(); m_afl.delete(); m_inflight.delete();
        for (int k = 0; k < FL; k++) begin m_sfl.push_back(ARF + k); m_afl.push_back(ARF + k); end
        m_recover = 0; m_ovalid = 0;
    endtask

    task automatic idle();
        s_valid = 0; s_oready = 1; s_flush = 0; s_mask = '0;
        for (int j = 0; j < RN; j++) begin s_dst[j] = 0; s_src[j][0] = 0; s_src[j][1] = 0; end
        for (int p = 0; p < CM; p++) s_cm[p] = 0;
    endtask

    task automatic set_slot(input int j, input int dst, input int s0, input int s1);
        s_valid = 1; s_mask[j] = 1'b1; s_dst[j] = dst; s_src[j][0] = s0; s_src[j][1] = s1;
    endtask

    task automatic drive_idle();
        in_valid_i = 0; in_mask_i = '0; in_src_i = '0; in_dst_i = '0; out_ready_i = 1;
        flush_i = 0; cm_valid_i = '0; cm_dst_i = '0; cm_pdst_i = '0; cm_pold_i = '0;
    endtask

    task automatic run_cycle();
        bit exp_rdy;
        int ncm;
        @(negedge clk);
        check("out_valid", 64'(out_valid_o), 64'(m_ovalid));
        check("flush_ack", 64'(flush_ack_o), 64'(m_recover));
        if (m_ovalid) begin
            check("out_mask", 64'(out_mask_o), 64'(m_omask));
            check("out_psrc", 64'(out_psrc_o), 64'(m_opsrc));
            check("out_pdst", 64'(out_pdst_o), 64'(m_opdst));
            check("out_pold", 64'(out_pold_o), 64'(m_opold));
        end
        in_valid_i = s_valid; in_mask_i = s_mask; out_ready_i = s_oready; flush_i = s_flush;
        for (int j = 0; j < RN; j++) begin
            in_dst_i[j*AW +: AW] = AW'(s_dst[j]);
            for (int s = 0; s < 2; s++) in_src_i[(2*j+s)*AW +: AW] = AW'(s_src[j][s]);
        end
        cm_valid_i = '0; cm_dst_i = '0; cm_pdst_i = '0; cm_pold_i = '0;
        ncm = 0;
        for (int p = 0; p < CM; p++) begin
            if (s_cm[p] == 1 && ncm < m_inflight.size()) begin
                cm_valid_i[p] = 1'b1;
                cm_dst_i[p*AW +: AW]  = AW'(m_inflight[ncm].dst);
                cm_pdst_i[p*PW +: PW] = PW'(m_inflight[ncm].pdst);
                cm_pold_i[p*PW +: PW] = PW'(m_inflight[ncm].pold);
                ncm++;
            end else if (s_cm[p] == 2) begin
                cm_valid_i[p] = 1'b1;
                cm_pdst_i[p*PW +: PW] = PW'($urandom_range(0, 63));
                cm_pold_i[p*PW +: PW] = PW'($urandom_range(0, 63));
            end
        end
        #1;
        exp_rdy = !m_recover && !s_flush && (m_sfl.size() >= RN) && (!m_ovalid || s_oready);
        check("in_ready", 64'(in_ready_o), 64'(exp_rdy));
        repeat (ncm) begin
            uop_t u;
            u = m_inflight.pop_front();
            m_arch[u.dst] = u.pdst;
            void'(m_afl.pop_front());
            m_afl.push_back(u.pold);
            m_sfl.push_back(u.pold);
        end
        if (m_recover) begin
            m_spec = m_arch; m_sfl = m_afl; m_inflight.delete();
            m_ovalid = 0; m_recover = 0;
        end else if (s_flush) begin
            m_recover = 1; m_ovalid = 0;
        end else if (s_valid && exp_rdy) begin
            m_omask = s_mask; m_opsrc = '0; m_opdst = '0; m_opold = '0;
            for (int j = 0; j < RN; j++) begin
                for (int s = 0; s < 2; s++) m_opsrc[(2*j+s)*PW +: PW] = PW'(m_spec[s_src[j][s]]);
                if (s_mask[j] && s_dst[j] != 0) begin
                    uop_t u;
                    u.dst = s_dst[j]; u.pold = m_spec[s_dst[j]]; u.pdst = m_sfl.pop_front();
                    m_spec[u.dst] = u.pdst;
                    m_opdst[j*PW +: PW] = PW'(u.pdst);
                    m_opold[j*PW +: PW] = PW'(u.pold);
                    m_inflight.push_back(u);
                end
            end
            m_ovalid = 1;
        end else if (s_oready) begin
            m_ovalid = 0;
        end
        @(posedge clk);
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        drive_idle(); idle(); model_reset();
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid_o), 64'd0);
        check("rst_flush_ack", 64'(flush_ack_o), 64'd0);
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic rand_stim(input int flush_pct);
        int r;
        s_valid  = ($urandom_range(0, 99) < 80);
        s_mask   = RN'($urandom_range(0, 3));
        s_oready = ($urandom_range(0, 99) < 75);
        s_flush  = ($urandom_range(0, 99) < flush_pct);
        for (int j = 0; j < RN; j++) begin
            s_dst[j] = ($urandom_range(0, 5) == 0) ? 0 :
                       ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 7)) : int'($urandom_range(1, ARF-1));
            for (int s = 0; s < 2; s++)
                s_src[j][s] = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, ARF-1));
        end
        for (int p = 0; p < CM; p++) begin
            r = int'($urandom_range(0, 99));
            s_cm[p] = (r < 45) ? 1 : (r < 55) ? 2 : 0;
        end
    endtask

    initial begin
        rst = 1'b1;
        drive_idle();
        model_reset();
        repeat (2) @(posedge clk);
        do_reset();

        // first group after reset: fresh pregs, arch pold, bypass into slot 1
        idle(); set_slot(0, 1, 3, 0); set_slot(1, 2, 1, 0);
        run_cycle();
        #1;
        check("g0_pdst", 64'(out_pdst_o), 64'((33 << PW) | 32));
        check("g0_pold", 64'(out_pold_o), 64'((2 << PW) | 1));
        check("g0_psrc_bypass", 64'(out_psrc_o[2*PW +: PW]), 64'd32);
        check("g0_psrc_rat", 64'(out_psrc_o[0 +: PW]), 64'd3);
        // same dst in both slots, then a reader of that areg
        idle(); set_slot(0, 5, 0, 0); set_slot(1, 5, 5, 0); run_cycle();
        idle(); set_slot(0, 6, 5, 5); run_cycle();
        // stall: out_ready low for three cycles with a group waiting
        repeat (3) begin idle(); set_slot(0, 7, 5, 1); s_oready = 0; run_cycle(); end
        idle(); run_cycle(); run_cycle();

        // drain the free list until ready drops, then commit to restore it
        do_reset();
        for (int k = 0; k < 40 && m_sfl.size() >= RN; k++) begin
            idle(); set_slot(0, (k % 31) + 1, k % 32, 0); set_slot(1, ((k + 7) % 31) + 1, 0, 1);
            run_cycle();
        end
        #1 check("drain_ready_low", 64'(in_ready_o), 64'd0);
        idle(); set_slot(0, 9, 0, 0); set_slot(1, 10, 0, 0); s_cm[0] = 1; s_cm[1] = 1; run_cycle();
        idle(); set_slot(0, 9, 0, 0); set_slot(1, 10, 0, 0); run_cycle();
        idle(); run_cycle();

        // three groups, one commit, flush, recover, then reuse of squashed pregs
        do_reset();
        idle(); set_slot(0, 1, 0, 0); set_slot(1, 2, 0, 0); run_cycle();
        idle(); set_slot(0, 3, 0, 0); set_slot(1, 4, 0, 0); run_cycle();
        idle(); set_slot(0, 5, 0, 0); set_slot(1, 6, 0, 0); run_cycle();
        idle(); s_cm[0] = 1; run_cycle();
        idle(); s_flush = 1; run_cycle();
        #1 check("flush_ack_high", 64'(flush_ack_o), 64'd1);
        idle(); run_cycle();
        idle(); set_slot(0, 7, 1, 2); set_slot(1, 8, 0, 0); run_cycle();
        #1;
        check("rec_psrc", 64'(out_psrc_o[0 +: 2*PW]), 64'((2 << PW) | 32));
        check("rec_pdst", 64'(out_pdst_o), 64'((34 << PW) | 33));
        idle(); run_cycle();

        // reset asserted in the middle of RECOVER
        idle(); set_slot(0, 4, 0, 0); run_cycle();
        idle(); s_flush = 1; run_cycle();
        #1 check("ack_before_rst", 64'(flush_ack_o), 64'd1);
        do_reset();
        idle(); set_slot(0, 1, 0, 0); set_slot(1, 2, 1, 0); run_cycle();
        #1 check("post_rst_pdst", 64'(out_pdst_o), 64'((33 << PW) | 32));
        idle(); run_cycle();

        // randomized traffic with commits, noise commits and occasional flushes
        do_reset();
        repeat (1500) begin rand_stim(2); run_cycle(); end
        repeat (4) begin idle(); run_cycle(); end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/r_rename_ckpt.md
R_RENAME_CKPT -- requirements
Module: r_rename_ckpt

Interface
REQ-001 Parameters (name, default, meaning):
- RN_WIDTH, 2, rename slots per group
- ARF_DEPTH, 32, architectural registers
- PRF_DEPTH, 64, physical registers
- CM_WIDTH, 2, commit ports
- Derived: AW = clog2(ARF_DEPTH), PW = clog2(PRF_DEPTH).

REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, single clock
- rst, in, 1, asynchronous active-high reset
- in_valid_i, in, 1, group valid
- in_ready_o, out, 1, group accepted
- in_mask_i, in, RN_WIDTH, per-slot valid
- in_src_i, in, RN_WIDTH*2*AW, source areg ids
- in_dst_i, in, RN_WIDTH*AW, dest areg ids
- out_valid_o, out, 1, renamed group valid
- out_ready_i, in, 1, downstream accepts
- out_mask_o, out, RN_WIDTH, slot mask
- out_psrc_o, out, RN_WIDTH*2*PW, source pregs
- out_pdst_o, out, RN_WIDTH*PW, new dest pregs
- out_pold_o, out, RN_WIDTH*PW, previous dest mapping
- cm_valid_i, in, CM_WIDTH, commit valid
- cm_dst_i, in, CM_WIDTH*AW, committed areg
- cm_pdst_i, in, CM_WIDTH*PW, committed new preg
- cm_pold_i, in, CM_WIDTH*PW, preg to free
- flush_i, in, 1, squash all speculative state
- flush_ack_o, out, 1, recovery done

Function
REQ-003 Spec RAT and arch RAT: ARF_DEPTH x PW each. Free list: circular FIFO of FL = PRF_DEPTH-ARF_DEPTH entries with spec head, committed head, tail, and count.
REQ-004 areg 0 is never renamed: it always reads preg 0, allocates nothing, and its pdst/pold outputs are 0.
REQ-005 A slot needs a preg iff its mask bit is set and its dst != 0; N = number of such slots.
REQ-006 The group is accepted when in_valid_i & in_ready_o.
- in_ready_o = (state==RUN) & (count >= RN_WIDTH) & (!out_valid_o | out_ready_i).
- The count condition is conservative: it does not depend on N.
REQ-007 Slots needing a preg take consecutive free-list entries from spec head in slot order; spec head advances by N mod FL.
REQ-008 Intra-group bypass: a slot j source matching dst of an earlier needing slot i<j takes the youngest such pdst, otherwise the spec RAT value. pold takes the same bypass.
REQ-009 On acceptance, the spec RAT is written with every needing slot's pdst. When two slots share a dst, the higher slot wins.
REQ-010 Output register latency is 1 cycle. Outputs hold while out_valid_o & !out_ready_i.
REQ-011 Commit, per valid port with cm_dst != 0:
- arch RAT[cm_dst] <= cm_pdst (higher port wins on the same dst)
- cm_pold is pushed at tail in port order
- committed head advances by the number of such ports.
REQ-012 Count update per cycle: count += pushes - allocations. Count never exceeds FL; overflow is a caller error and is flagged by an assertion.
REQ-013 FSM RUN -> RECOVER on flush_i. In RECOVER (exactly 1 cycle):
- spec RAT <= arch RAT
- spec head <= committed head
- count <= tail - committed head (mod FL, with full = FL)
- out_valid_o <= 0
- flush_ack_o = 1
- return to RUN.
REQ-014 Commits in the flush cycle and in the RECOVER cycle are applied before the copy. The copied values include them.
REQ-015 In the flush_i cycle, in_ready_o = 0 and out_valid_o is cleared next edge. A flush asserted during RECOVER is absorbed.
REQ-016 Head and tail pointers wrap modulo FL. FL need not be a power of 2: compare-and-subtract is required.

Reset
REQ-017 While rst is high, asynchronously:
- spec RAT and arch RAT entry i = i
- free list entry k = ARF_DEPTH+k
- all heads and tail = 0, count = FL
- state = RUN, out_valid_o = 0, flush_ack_o = 0.
REQ-018 Reset overrides flush and commit at every point, including mid-RECOVER.

Structure
REQ-019 Parameters, derived widths and the FSM state enum belong in the shared package.
REQ-020 One sub-module, r_rename_freelist: FIFO, heads, tail and count, with alloc/push/restore ports.

Verification
REQ-021 After reset, group {dst 1, dst 2, src 1} -> pdst 32,33; pold 1,2; slot1 psrc 32 via bypass.
REQ-022 Two slots with dst 5 -> slot1 pold = slot0 pdst; next group reading areg 5 gets slot1 pdst.
REQ-023 Allocate until count < RN_WIDTH -> in_ready_o = 0. Commit frees pold -> ready returns the cycle after count >= RN_WIDTH.
REQ-024 Rename 3 groups, commit 1, flush -> flush_ack_o high 1 cycle later. Reading areg shows the committed preg, and the next allocation reuses the squashed pregs.
REQ-025 Hold out_ready_i = 0 for 3 cycles -> outputs stable, in_ready_o = 0, no allocation.
REQ-026 Assert rst during RECOVER -> all state returns to reset values and flush_ack_o = 0.
